riscv_aes_ctrl: RTL and testbench

RISCV_AES_CTRL -- requirements
Module: riscv_aes_ctrl

---
 rtl/riscv_aes_pkg.sv | 15 +
 rtl/riscv_aes_ctrl.sv | 140 ++++++++++++++
 tb/tb_riscv_aes_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_aes_pkg.sv
// rtl/riscv_aes_pkg.sv - shared types and constants for the AES coprocessor writeback controller
package riscv_aes_pkg;

    typedef enum logic [2:0] {
        AES_IDLE,
        AES_RUN,
        AES_WB_REQ,
        AES_WB_WAIT,
        AES_DONE
    } aes_state_e;

    localparam int unsigned AES_NUM_WORDS = 4;
    localparam logic [3:0]  AES_BE_WORD   = 4'hF;

endpackage

// File: rtl/riscv_aes_ctrl.sv
// rtl/riscv_aes_ctrl.sv - starts the AES core, buffers its result and writes it back over OBI.
// AES_CTRL_WATCHDOG_EN builds a core-done watchdog that raises a sticky error_o.
module riscv_aes_ctrl
    import riscv_aes_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned NUM_WORDS      = AES_NUM_WORDS,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            aes_start_i,
    input  logic [DATA_WIDTH-1:0]           wb_addr_i,
    output logic                            core_start_o,
    input  logic                            core_done_i,
    input  logic [NUM_WORDS*DATA_WIDTH-1:0] core_result_i,
    output logic                            data_req_o,
    input  logic                            data_gnt_i,
    input  logic                            data_rvalid_i,
    output logic [DATA_WIDTH-1:0]           data_addr_o,
    output logic [DATA_WIDTH-1:0]           data_wdata_o,
    output logic                            data_we_o,
    output logic [3:0]                      data_be_o,
    output logic                            busy_o,
    output logic                            done_o,
    output logic                            error_o
);

    localparam int unsigned IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    aes_state_e              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   base_q, base_d;
    logic [DATA_WIDTH-1:0]   buf_q [NUM_WORDS];
    logic [DATA_WIDTH-1:0]   buf_d [NUM_WORDS];
    logic                    core_start_q, core_start_d;
    logic                    timeout_fire;
    logic                    wb_active;

`ifdef AES_CTRL_WATCHDOG_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wd_q, wd_d;
    logic             error_q;

    // Counts RUN cycles; fires on the TIMEOUT_CYCLES-th one unless the core finishes then.
    assign timeout_fire = (state_q == AES_RUN) && !core_done_i
                          && (wd_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign wd_d         = (state_q == AES_RUN) ? wd_q + 1'b1 : '0;
    assign error_o      = error_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q    <= '0;
            error_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            error_q <= error_q | timeout_fire;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign timeout_fire       = 1'b0;
    assign error_o            = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        base_d       = base_q;
        buf_d        = buf_q;
        core_start_d = 1'b0;
        unique case (state_q)
            AES_IDLE: begin
                if (aes_start_i) begin
                    base_d       = wb_addr_i;
                    core_start_d = 1'b1;
                    state_d      = AES_RUN;
                end
            end
            AES_RUN: begin
                if (core_done_i) begin
                    for (int i = 0; i < NUM_WORDS; i++) begin
                        buf_d[i] = core_result_i[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                    idx_d   = '0;
                    state_d = AES_WB_REQ;
                end else if (timeout_fire) begin
                    state_d = AES_DONE;
                end
            end
            AES_WB_REQ: begin
                if (data_gnt_i) state_d = AES_WB_WAIT;
            end
            AES_WB_WAIT: begin
                if (data_rvalid_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = AES_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = AES_WB_REQ;
                    end
                end
            end
            AES_DONE: state_d = AES_IDLE;
            default:  state_d = AES_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= AES_IDLE;
            idx_q        <= '0;
            base_q       <= '0;
            core_start_q <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) buf_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            base_q       <= base_d;
            core_start_q <= core_start_d;
            buf_q        <= buf_d;
        end
    end

    // Request fields are zero outside WB_REQ so the bus sees nothing stale.
    assign wb_active    = (state_q == AES_WB_REQ);
    assign data_req_o   = wb_active;
    assign data_we_o    = wb_active;
    assign data_be_o    = wb_active ? AES_BE_WORD : 4'h0;
    assign data_addr_o  = wb_active ? base_q + (DATA_WIDTH'(idx_q) << 2) : '0;
    assign data_wdata_o = wb_active ? buf_q[idx_q] : '0;
    assign core_start_o = core_start_q;
    assign busy_o       = (state_q != AES_IDLE);
    assign done_o       = (state_q == AES_DONE);

endmodule

// File: tb/tb_riscv_aes_ctrl.sv
// tb/tb_riscv_aes_ctrl.sv - directed scoreboard bench for riscv_aes_ctrl
module tb_riscv_aes_ctrl;

    localparam int DW = 32;
    localparam int NW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              aes_start_i;
    logic [DW-1:0]     wb_addr_i;
    logic              core_start_o;
    logic              core_done_i;
    logic [NW*DW-1:0]  core_result_i;
    logic              data_req_o;
    logic              data_gnt_i;
    logic              data_rvalid_i;
    logic [DW-1:0]     data_addr_o;
    logic [DW-1:0]     data_wdata_o;
    logic              data_we_o;
    logic [3:0]        data_be_o;
    logic              busy_o;
    logic              done_o;
    logic              error_o;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  n_cs  = 0;

    always #5 clk = ~clk;

    riscv_aes_ctrl #(
        .DATA_WIDTH    (DW),
        .NUM_WORDS     (NW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .aes_start_i  (aes_start_i),
        .wb_addr_i    (wb_addr_i),
        .core_start_o (core_start_o),
        .core_done_i  (core_done_i),
        .core_result_i(core_result_i),
        .data_req_o   (data_req_o),
        .data_gnt_i   (data_gnt_i),
        .data_rvalid_i(data_rvalid_i),
        .data_addr_o  (data_addr_o),
        .data_wdata_o (data_wdata_o),
        .data_we_o    (data_we_o),
        .data_be_o    (data_be_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o)
    );

    always @(negedge clk) if (core_start_o) n_cs++;

    initial begin
        #500000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_core_start"}, core_start_o, 0);
        chk({tag, "_req"},        data_req_o,   0);
        chk({tag, "_we"},         data_we_o,    0);
        chk({tag, "_be"},         data_be_o,    0);
        chk({tag, "_addr"},       data_addr_o,  0);
        chk({tag, "_wdata"},      data_wdata_o, 0);
        chk({tag, "_busy"},       busy_o,       0);
        chk({tag, "_done"},       done_o,       0);
        chk({tag, "_error"},      error_o,      0);
    endtask

    // Drives the start pulse and pushes the writes the operation must produce.
    task automatic start_op(input string tag, input logic [31:0] base,
                            input logic [NW*DW-1:0] res, input logic with_done);
        wr_t e;
        aes_start_i = 1'b1;
        wb_addr_i   = base;
        core_done_i = with_done;
        for (int i = 0; i < NW; i++) begin
            e.addr = base + 32'(4 * i);
            e.data = res[i*DW +: DW];
            exp_q.push_back(e);
        end
        step();
        aes_start_i = 1'b0;
        core_done_i = 1'b0;
        chk({tag, "_core_start"}, core_start_o, 1);
        chk({tag, "_busy"},       busy_o,       1);
        chk({tag, "_no_req"},     data_req_o,   0);
    endtask

    task automatic run_core(input int wait_cycles, input logic [NW*DW-1:0] res);
        repeat (wait_cycles) step();
        core_done_i   = 1'b1;
        core_result_i = res;
        step();
        core_done_i   = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int k = 0;
        while (!data_req_o && k < 50) begin
            step();
            k++;
        end
        chk({tag, "_req_seen"}, data_req_o, 1);
    endtask

    // Serves n_words writes; word slow_word sees its grant delayed by delay cycles.
    task automatic serve_writes(input string tag, input int n_words,
                                input int slow_word, input int delay);
        wr_t e;
        for (int w = 0; w < n_words; w++) begin
            wait_req(tag);
            chk({tag, "_sb_nonempty"}, exp_q.size() > 0, 1);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            chk({tag, "_addr"},  data_addr_o,  e.addr);
            chk({tag, "_wdata"}, data_wdata_o, e.data);
            chk({tag, "_be"},    data_be_o,    4'hF);
            chk({tag, "_we"},    data_we_o,    1);
            if (w == slow_word) begin
                for (int d = 0; d < delay; d++) begin
                    if (d == 0) begin
                        core_done_i   = 1'b1;
                        core_result_i = '1;
                    end
                    step();
                    core_done_i = 1'b0;
                    chk({tag, "_stall_req"},   data_req_o,   1);
                    chk({tag, "_stall_addr"},  data_addr_o,  e.addr);
                    chk({tag, "_stall_wdata"}, data_wdata_o, e.data);
                end
            end
            data_gnt_i = 1'b1;
            step();
            data_gnt_i = 1'b0;
            chk({tag, "_wait_no_req"}, data_req_o, 0);
            data_rvalid_i = 1'b1;
            step();
            data_rvalid_i = 1'b0;
        end
    endtask

    task automatic finish_op(input string tag);
        chk({tag, "_done_pulse"}, done_o, 1);
        chk({tag, "_done_busy"},  busy_o, 1);
        chk({tag, "_done_req"},   data_req_o, 0);
        step();
        chk({tag, "_done_low"},   done_o, 0);
        chk({tag, "_idle_busy"},  busy_o, 0);
        chk({tag, "_sb_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        logic [NW*DW-1:0] res;
        int cs0;

        rst_n         = 1'b0;
        aes_start_i   = 1'b0;
        wb_addr_i     = '0;
        core_done_i   = 1'b0;
        core_result_i = '0;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        repeat (2) step();
        chk_zero("reset");
        rst_n = 1'b1;
        step();
        chk_zero("post_reset");

        // Basic operation, zero-wait bus.
        res = {32'd44, 32'd33, 32'd22, 32'd11};
        cs0 = n_cs;
        start_op("t1", 32'h1000, res, 1'b0);
        run_core(8, res);
        serve_writes("t1", NW, -1, 0);
        finish_op("t1");
        chk("t1_core_start_count", n_cs - cs0, 1);

        // Grant held off on word 2; stray core_done during the stall.
        res = {32'hD4D4D4D4, 32'hC3C3C3C3, 32'hB2B2B2B2, 32'hA1A1A1A1};
        start_op("t2", 32'h2000, res, 1'b0);
        run_core(3, res);
        serve_writes("t2", NW, 2, 3);
        finish_op("t2");

        // Second start during RUN is ignored.
        res = {32'h4, 32'h3, 32'h2, 32'h1};
        cs0 = n_cs;
        start_op("t3", 32'h3000, res, 1'b0);
        step();
        aes_start_i = 1'b1;
        wb_addr_i   = 32'h5000;
        step();
        aes_start_i = 1'b0;
        chk("t3_no_restart_pulse", core_start_o, 0);
        run_core(4, res);
        serve_writes("t3", NW, -1, 0);
        finish_op("t3");
        chk("t3_core_start_count", n_cs - cs0, 1);

        // Address wrap; start and done together in IDLE -> done ignored.
        res = {32'h0000_0004, 32'h0000_0003, 32'hFFFF_FFFC, 32'hFFFF_FFF8};
        start_op("t4", 32'hFFFF_FFF8, res, 1'b1);
        step();
        chk("t4_still_run", data_req_o, 0);
        chk("t4_still_busy", busy_o, 1);
        run_core(2, res);
        serve_writes("t4", NW, -1, 0);
        finish_op("t4");

        // Reset while waiting for the response of word 1.
        res = {32'h88, 32'h77, 32'h66, 32'h55};
        start_op("t5", 32'h4000, res, 1'b0);
        run_core(2, res);
        serve_writes("t5", 1, -1, 0);
        wait_req("t5_w1");
        chk("t5_w1_addr", data_addr_o, 32'h4004);
        data_gnt_i = 1'b1;
        step();
        data_gnt_i = 1'b0;
        chk("t5_in_wait", data_req_o, 0);
        rst_n = 1'b0;
        step();
        chk_zero("t5_reset");
        exp_q.delete();
        rst_n = 1'b1;
        step();
        res = {32'h99, 32'hAA, 32'hBB, 32'hCC};
        start_op("t6", 32'h6000, res, 1'b0);
        run_core(5, res);
        serve_writes("t6", NW, -1, 0);
        finish_op("t6");

`ifdef AES_CTRL_WATCHDOG_EN
        // Core never finishes: watchdog ends the operation after 8 RUN cycles.
        aes_start_i = 1'b1;
        wb_addr_i   = 32'h8000;
        step();
        aes_start_i = 1'b0;
        chk("wd_error_early", error_o, 0);
        for (int i = 0; i < 7; i++) begin
            chk("wd_no_req", data_req_o, 0);
            step();
        end
        chk("wd_error_at_8", error_o, 0);
        chk("wd_not_done", done_o, 0);
        step();
        chk("wd_done_pulse", done_o, 1);
        chk("wd_error_set", error_o, 1);
        chk("wd_no_req_done", data_req_o, 0);
        step();
        chk("wd_idle", busy_o, 0);
        chk("wd_error_sticky", error_o, 1);
`else
        // No watchdog: RUN waits well past the timeout value without error.
        res = {32'h1234, 32'h5678, 32'h9ABC, 32'hDEF0};
        start_op("t7", 32'h7000, res, 1'b0);
        repeat (300) step();
        chk("t7_no_error", error_o, 0);
        chk("t7_still_busy", busy_o, 1);
        chk("t7_no_done", done_o, 0);
        run_core(0, res);
        serve_writes("t7", NW, -1, 0);
        finish_op("t7");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
